// File: rtl/drfm_pkg.sv
// Shared types and constants for the DRFM host command sequencer.
// Bit positions assume a 49-bit command word.
package drfm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_APPLY,
        ST_LOAD_REQ
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_DELAY,
        OP_DOPPLER,
        OP_SCALE,
        OP_LOAD
    } opcode_t;

    localparam logic [3:0] CODE_DELAY   = 4'b0001;
    localparam logic [3:0] CODE_DOPPLER = 4'b1000;
    localparam logic [3:0] CODE_SCALE   = 4'b0010;
    localparam logic [3:0] CODE_LOAD    = 4'b0100;
    localparam logic [3:0] CODE_IDLE    = 4'b0000;

    localparam int DELAY_FLAG   = 10;
    localparam int DOPPLER_FLAG = 20;
    localparam int SCALE_FLAG   = 30;
    localparam int LAST_FLAG    = 47;
    localparam int LOAD_FLAG    = 48;

    localparam int DELAY_LSB   = 0;
    localparam int DELAY_MSB   = 9;
    localparam int DOPPLER_LSB = 10;
    localparam int DOPPLER_MSB = 19;
    localparam int SCALE_LSB   = 20;
    localparam int SCALE_MSB   = 29;
    localparam int DATA_LSB    = 31;
    localparam int DATA_MSB    = 46;

    function automatic logic [3:0] op_to_code(opcode_t op);
        case (op)
            OP_DELAY:   return CODE_DELAY;
            OP_DOPPLER: return CODE_DOPPLER;
            OP_SCALE:   return CODE_SCALE;
            OP_LOAD:    return CODE_LOAD;
            default:    return CODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/drfm_cmd_decode.sv
// Combinational command decoder: first matching flag wins (delay, doppler,
// scale, load); a word with none of them set is a NOP.
module drfm_cmd_decode import drfm_pkg::*; #(
    parameter int CMD_W = 49
) (
    input  logic [CMD_W-1:0] i_cmd,
    output opcode_t          o_opcode,
    output logic [9:0]       o_payload,
    output logic [15:0]      o_data,
    output logic             o_last
);

    always_comb begin
        o_opcode  = OP_NOP;
        o_payload = '0;
        o_data    = i_cmd[DATA_MSB:DATA_LSB];
        o_last    = i_cmd[LAST_FLAG];
        if (i_cmd[DELAY_FLAG]) begin
            o_opcode  = OP_DELAY;
            o_payload = i_cmd[DELAY_MSB:DELAY_LSB];
        end else if (i_cmd[DOPPLER_FLAG]) begin
            o_opcode  = OP_DOPPLER;
            o_payload = i_cmd[DOPPLER_MSB:DOPPLER_LSB];
        end else if (i_cmd[SCALE_FLAG]) begin
            o_opcode  = OP_SCALE;
            o_payload = i_cmd[SCALE_MSB:SCALE_LSB];
        end else if (i_cmd[LOAD_FLAG]) begin
            o_opcode  = OP_LOAD;
            o_payload = i_cmd[DATA_LSB+9:DATA_LSB];
        end
    end

endmodule

// File: rtl/drfm_cmd_sequencer.sv
// Host command sequencer: applies DRFM config updates and turns LOAD commands
// into single-word SDRAM writes over a req/ack handshake with timeout.
module drfm_cmd_sequencer import drfm_pkg::*; #(
    parameter int CMD_W       = 49,
    parameter int ADDR_W      = 24,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [CMD_W-1:0]  cmd_word,
    output logic              cmd_ready,
    input  logic              err_clr,
    output logic [9:0]        delay_val,
    output logic [9:0]        doppler_val,
    output logic [9:0]        scale_val,
    output logic              cfg_strobe,
    output logic [3:0]        state_code,
    output logic [9:0]        led,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [15:0]       mem_wr_data,
    input  logic              mem_wr_ack,
    output logic              load_done,
    output logic              err_timeout,
    output logic              err_overrun,
    output state_t            o_dbg_state
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(ACK_TIMEOUT - 1);

    state_t            r_state, w_state_nxt;
    logic [CMD_W-1:0]  r_cmd;
    logic [9:0]        r_delay, r_doppler, r_scale, r_led;
    logic [3:0]        r_code;
    logic              r_strobe, r_done, r_req, r_err_to, r_err_ov;
    logic [ADDR_W-1:0] r_addr, r_wr_ptr;
    logic [15:0]       r_data;
    logic [CNT_W-1:0]  r_cnt;

    opcode_t           w_opcode;
    logic [9:0]        w_payload;
    logic [15:0]       w_data;
    logic              w_last, w_cmd_ready, w_ack_hit, w_timeout_hit;

    drfm_cmd_decode #(.CMD_W(CMD_W)) u_decode (
        .i_cmd     (r_cmd),
        .o_opcode  (w_opcode),
        .o_payload (w_payload),
        .o_data    (w_data),
        .o_last    (w_last)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // An ack seen on the terminal-count cycle is taken before the timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_ready   = (r_state == ST_IDLE);
        w_ack_hit     = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE:     if (cmd_valid) w_state_nxt = ST_DECODE;
            ST_DECODE:   w_state_nxt = (w_opcode == OP_LOAD) ? ST_LOAD_REQ : ST_APPLY;
            ST_APPLY:    w_state_nxt = ST_IDLE;
            ST_LOAD_REQ: begin
                if (mem_wr_ack && r_req) begin
                    w_ack_hit   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_TERM) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_cmd     <= '0;
            r_delay   <= '0;
            r_doppler <= '0;
            r_scale   <= '0;
            r_led     <= '0;
            r_code    <= CODE_IDLE;
            r_strobe  <= 1'b0;
            r_done    <= 1'b0;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_wr_ptr  <= '0;
            r_cnt     <= '0;
        end else begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: if (cmd_valid) r_cmd <= cmd_word;
                ST_DECODE: begin
                    if (w_opcode == OP_LOAD) begin
                        r_req  <= 1'b1;
                        r_addr <= r_wr_ptr;
                        r_data <= w_data;
                        r_code <= CODE_LOAD;
                        r_led  <= w_payload;
                        r_cnt  <= '0;
                    end
                end
                ST_APPLY: begin
                    r_code <= op_to_code(w_opcode);
                    if (w_opcode != OP_NOP) begin
                        r_led    <= w_payload;
                        r_strobe <= 1'b1;
                    end
                    case (w_opcode)
                        OP_DELAY:   r_delay   <= w_payload;
                        OP_DOPPLER: r_doppler <= w_payload;
                        OP_SCALE:   r_scale   <= w_payload;
                        default:    ;
                    endcase
                end
                ST_LOAD_REQ: begin
                    if (w_ack_hit) begin
                        r_req <= 1'b0;
                        if (w_last) begin
                            r_wr_ptr <= '0;
                            r_done   <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                        end
                    end else if (w_timeout_hit) begin
                        r_req <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky flags: a new error event outranks a simultaneous clear.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_err_to <= 1'b0;
            r_err_ov <= 1'b0;
        end else begin
            if (w_timeout_hit)     r_err_to <= 1'b1;
            else if (err_clr)      r_err_to <= 1'b0;
            if (cmd_valid && !w_cmd_ready) r_err_ov <= 1'b1;
            else if (err_clr)              r_err_ov <= 1'b0;
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign delay_val   = r_delay;
    assign doppler_val = r_doppler;
    assign scale_val   = r_scale;
    assign cfg_strobe  = r_strobe;
    assign state_code  = r_code;
    assign led         = r_led;
    assign mem_wr_req  = r_req;
    assign mem_wr_addr = r_addr;
    assign mem_wr_data = r_data;
    assign load_done   = r_done;
    assign err_timeout = r_err_to;
    assign err_overrun = r_err_ov;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_drfm_cmd_sequencer.sv
// Directed-plus-random bench for drfm_cmd_sequencer against a behavioural
// model of config registers, write pointer, sticky errors and expected writes.
module tb_drfm_cmd_sequencer;
    import drfm_pkg::*;

    localparam int CMD_W       = 49;
    localparam int ADDR_W      = 3;
    localparam int ACK_TIMEOUT = 8;

    logic              CLK = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [CMD_W-1:0]  cmd_word = '0;
    logic              err_clr = 1'b0;
    logic              mem_wr_ack = 1'b0;
    logic              cmd_ready, cfg_strobe, mem_wr_req, load_done;
    logic              err_timeout, err_overrun;
    logic [9:0]        delay_val, doppler_val, scale_val, led;
    logic [3:0]        state_code;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [15:0]       mem_wr_data;
    state_t            dbg_state;

    drfm_cmd_sequencer #(.CMD_W(CMD_W), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
        .cmd_ready(cmd_ready), .err_clr(err_clr), .delay_val(delay_val),
        .doppler_val(doppler_val), .scale_val(scale_val), .cfg_strobe(cfg_strobe),
        .state_code(state_code), .led(led), .mem_wr_req(mem_wr_req),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
        .load_done(load_done), .err_timeout(err_timeout), .err_overrun(err_overrun),
        .o_dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int tests = 0;
    int fails = 0;

    // behavioural model
    logic [9:0]        m_delay, m_doppler, m_scale, m_led;
    logic [3:0]        m_code;
    logic [ADDR_W-1:0] m_ptr;
    logic              m_err_to, m_err_ov;
    logic [ADDR_W+15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_delay = '0; m_doppler = '0; m_scale = '0; m_led = '0;
        m_code = '0; m_ptr = '0; m_err_to = 1'b0; m_err_ov = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, "/delay"},   32'(delay_val),   32'(m_delay));
        check({tag, "/doppler"}, 32'(doppler_val), 32'(m_doppler));
        check({tag, "/scale"},   32'(scale_val),   32'(m_scale));
        check({tag, "/code"},    32'(state_code),  32'(m_code));
        check({tag, "/led"},     32'(led),         32'(m_led));
        check({tag, "/err_to"},  32'(err_timeout), 32'(m_err_to));
        check({tag, "/err_ov"},  32'(err_overrun), 32'(m_err_ov));
        check({tag, "/ready"},   32'(cmd_ready),   32'd1);
    endtask

    // kind: 0 NOP, 1 DELAY, 2 DOPPLER, 3 SCALE, 4 LOAD; lower-priority flags stay random
    function automatic logic [CMD_W-1:0] rand_word(input int kind);
        logic [CMD_W-1:0] w;
        w = CMD_W'({$urandom(), $urandom()});
        case (kind)
            1: w[10] = 1'b1;
            2: begin w[10] = 1'b0; w[20] = 1'b1; end
            3: begin w[10] = 1'b0; w[20] = 1'b0; w[30] = 1'b1; end
            4: begin w[10] = 1'b0; w[20] = 1'b0; w[30] = 1'b0; w[48] = 1'b1; end
            default: begin w[10] = 1'b0; w[20] = 1'b0; w[30] = 1'b0; w[48] = 1'b0; end
        endcase
        return w;
    endfunction

    task automatic model_cfg(input logic [CMD_W-1:0] w, output int strobes);
        strobes = 1;
        if (w[10]) begin
            m_delay = w[9:0]; m_led = w[9:0]; m_code = 4'b0001;
        end else if (w[20]) begin
            m_doppler = w[19:10]; m_led = w[19:10]; m_code = 4'b1000;
        end else if (w[30]) begin
            m_scale = w[29:20]; m_led = w[29:20]; m_code = 4'b0010;
        end else begin
            m_code = 4'b0000; strobes = 0;
        end
    endtask

    // driver: config / NOP command, checked three cycles after cmd_valid
    task automatic send_cfg(input logic [CMD_W-1:0] w, input string tag);
        int s, exp_s;
        model_cfg(w, exp_s);
        cmd_word = w; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        s = int'(cfg_strobe);
        check({tag, "/busy"}, 32'(cmd_ready), 32'd0);
        tick(); s += int'(cfg_strobe);
        tick(); s += int'(cfg_strobe);
        check({tag, "/strobes"}, 32'(s), 32'(exp_s));
        check_state(tag);
    endtask

    // driver: LOAD command; ack_delay<0 means never ack, ovr_at>0 injects an overrun
    task automatic do_load(input logic [15:0] data, input logic last, input int ack_delay,
                           input int ovr_at, input logic ovr_clr, input string tag);
        logic [CMD_W-1:0] w;
        logic [ADDR_W+15:0] exp_wr;
        int hi, exp_hi;
        logic exp_acked;
        w = rand_word(4);
        w[46:31] = data;
        w[47] = last;
        exp_q.push_back({m_ptr, data});
        exp_wr = exp_q[0];
        m_code = 4'b0100;
        m_led = data[9:0];
        exp_acked = (ack_delay >= 0) && (ack_delay + 1 <= ACK_TIMEOUT);
        exp_hi = exp_acked ? ack_delay + 1 : ACK_TIMEOUT;
        cmd_word = w; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        hi = 0;
        while (mem_wr_req === 1'b1 && hi < 64) begin
            hi++;
            check({tag, "/wr"}, 32'({mem_wr_addr, mem_wr_data}), 32'(exp_wr));
            if (hi == ovr_at) begin
                cmd_word = rand_word($urandom_range(1, 3));
                cmd_valid = 1'b1;
                err_clr = ovr_clr;
                m_err_ov = 1'b1;
                if (ovr_clr) m_err_to = 1'b0;
            end
            if (ack_delay >= 0 && hi == ack_delay + 1) mem_wr_ack = 1'b1;
            tick();
            mem_wr_ack = 1'b0; cmd_valid = 1'b0; err_clr = 1'b0;
        end
        void'(exp_q.pop_front());
        check({tag, "/req_cycles"}, 32'(hi), 32'(exp_hi));
        if (exp_acked) begin
            if (last) m_ptr = '0;
            else      m_ptr = ADDR_W'((int'(m_ptr) + 1) % (1 << ADDR_W));
        end else begin
            m_err_to = 1'b1;
        end
        check({tag, "/load_done"}, 32'(load_done), 32'(exp_acked && last));
        check_state(tag);
        tick();
        check({tag, "/done_pulse"}, 32'(load_done), 32'd0);
    endtask

    initial begin
        logic [CMD_W-1:0] w;
        model_reset();
        repeat (3) @(posedge CLK);
        #1 reset = 1'b1;
        tick();
        check_state("reset");
        check("reset/req", 32'(mem_wr_req), 32'd0);

        w = '0; w[10] = 1'b1; w[9:0] = 10'h155;
        send_cfg(w, "delay_155");

        w = '0; w[10] = 1'b1; w[20] = 1'b1; w[19:10] = 10'h3FF; w[9:0] = 10'h001;
        send_cfg(w, "priority");

        for (int i = 0; i < 8; i++) send_cfg(rand_word($urandom_range(0, 3)), "rand_cfg");

        do_load(16'hBEEF, 1'b0, 5, 0, 1'b0, "load_beef");
        do_load(16'($urandom), 1'b1, 2, 0, 1'b0, "load_last");
        do_load(16'($urandom), 1'b0, -1, 0, 1'b0, "load_timeout");

        err_clr = 1'b1; tick(); err_clr = 1'b0;
        m_err_to = 1'b0;
        check_state("err_clr");

        do_load(16'($urandom), 1'b0, ACK_TIMEOUT - 1, 0, 1'b0, "ack_at_term");
        do_load(16'($urandom), 1'b0, $urandom_range(3, 6), 2, 1'b0, "overrun");

        err_clr = 1'b1; tick(); err_clr = 1'b0;
        m_err_ov = 1'b0;
        check_state("err_clr2");
        do_load(16'($urandom), 1'b0, -1, 2, 1'b1, "ovr_vs_clr");

        for (int i = 0; i < 8 && m_ptr != '1; i++)
            do_load(16'($urandom), 1'b0, $urandom_range(0, 4), 0, 1'b0, "fill");
        check("wrap/ptr_full", 32'(m_ptr), 32'((1 << ADDR_W) - 1));
        do_load(16'($urandom), 1'b0, $urandom_range(0, 4), 0, 1'b0, "wrap");
        do_load(16'($urandom), 1'b0, 1, 0, 1'b0, "after_wrap");

        for (int i = 0; i < 4; i++) send_cfg(rand_word($urandom_range(0, 3)), "rand_cfg2");

        cmd_word = rand_word(4); cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rst_mid/req_before", 32'(mem_wr_req), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_mid/req",   32'(mem_wr_req),  32'd0);
        check("rst_mid/addr",  32'(mem_wr_addr), 32'd0);
        check("rst_mid/data",  32'(mem_wr_data), 32'd0);
        check("rst_mid/done",  32'(load_done),   32'd0);
        check("rst_mid/strb",  32'(cfg_strobe),  32'd0);
        check_state("rst_mid");
        @(posedge CLK);
        #1 reset = 1'b1;
        tick();
        check_state("after_reset");
        do_load(16'($urandom), 1'b0, 0, 0, 1'b0, "post_reset_load");
        send_cfg(rand_word(2), "post_reset_cfg");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
